// File: rtl/msg_charset_checker.sv
// Charset validator for the decrypted-message RAM: streams one read per cycle, classifies each
// returned byte against the latched charset and reports pass/fail, first bad index and good-byte count.
module msg_charset_checker #(
  parameter int MSG_LEN     = 32,
  parameter int ADDR_W      = 5,
  parameter int RD_LATENCY  = 2,
  parameter int EARLY_ABORT = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [1:0]                   mode,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic [ADDR_W-1:0]            fail_index,
  output logic [$clog2(MSG_LEN+1)-1:0] valid_count,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wren,
  input  logic [7:0]                   mem_q
);

  localparam int                CNT_W    = $clog2(MSG_LEN + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MSG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic                r_busy;
  logic                r_done;
  logic                r_valid;
  logic                r_failed;
  logic [ADDR_W-1:0]   r_fail_index;
  logic [CNT_W-1:0]    r_valid_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_chk_ptr;
  // r_tag_v[k] set: a read issued k+1 cycles ago is still in flight.
  logic [RD_LATENCY-1:0] r_tag_v;

  logic w_classify;
  logic w_byte_ok;
  logic w_abort;
  logic w_last;

  function automatic logic f_in_set(input logic [1:0] m, input logic [7:0] b);
    logic is_lower, is_space, is_upper, is_digit, is_punct;
    is_lower = (b >= 8'h61) && (b <= 8'h7A);
    is_space = (b == 8'h20);
    is_upper = (b >= 8'h41) && (b <= 8'h5A);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
    is_punct = (b == 8'h2E) || (b == 8'h2C);
    case (m)
      2'd0:    f_in_set = is_lower | is_space;
      2'd1:    f_in_set = is_lower | is_space | is_upper;
      2'd2:    f_in_set = is_lower | is_space | is_upper | is_digit | is_punct;
      default: f_in_set = (b >= 8'h20) && (b <= 8'h7E);
    endcase
  endfunction

  assign w_classify = r_tag_v[RD_LATENCY-1];
  assign w_byte_ok  = f_in_set(r_mode, mem_q);
  assign w_abort    = (EARLY_ABORT != 0) && w_classify && !w_byte_ok;
  assign w_last     = (r_chk_ptr == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= 2'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_valid       <= 1'b0;
      r_failed      <= 1'b0;
      r_fail_index  <= '0;
      r_valid_count <= '0;
      r_addr        <= '0;
      r_chk_ptr     <= '0;
      r_tag_v       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every later assignment in this block
      // overrides an earlier default while all right-hand sides still see pre-edge values.
      for (int k = RD_LATENCY - 1; k > 0; k--) r_tag_v[k] <= r_tag_v[k-1];
      r_tag_v[0] <= 1'b0;

      if (w_classify) begin
        r_chk_ptr <= r_chk_ptr + 1'b1;
        if (w_byte_ok) begin
          if (r_valid_count != MAX_CNT) r_valid_count <= r_valid_count + 1'b1;
        end else if (!r_failed) begin
          r_failed     <= 1'b1;
          r_fail_index <= r_chk_ptr;
        end
      end

      // Early abort: freeze the address and drop every outstanding read.
      if (w_abort) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_valid <= 1'b0;
        r_tag_v <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_mode        <= mode;
              r_done        <= 1'b0;
              r_valid       <= 1'b0;
              r_failed      <= 1'b0;
              r_fail_index  <= '0;
              r_valid_count <= '0;
              r_addr        <= '0;
              r_chk_ptr     <= '0;
              r_busy        <= 1'b1;
              r_state       <= S_SCAN;
            end
          end
          S_SCAN: begin
            r_tag_v[0] <= 1'b1;
            if (r_addr == LAST_IDX) r_state <= S_DRAIN;
            else                    r_addr  <= r_addr + 1'b1;
          end
          S_DRAIN: begin
            if (w_classify && w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= !r_failed && w_byte_ok;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign valid       = r_valid;
  assign fail_index  = r_fail_index;
  assign valid_count = r_valid_count;
  assign mem_addr    = r_addr;
  assign mem_wren    = 1'b0;

endmodule

// File: tb/tb_msg_charset_checker.sv
// Self-checking bench: two checker instances (latency 2 with early abort, latency 3 scanning
// everything) share one message RAM and are compared every cycle against a behavioural model.
module tb_msg_charset_checker;

  localparam int MSG_LEN = 32;
  localparam int LAT_A   = 2;
  localparam int LAT_B   = 3;

  typedef struct {
    int done_cyc;
    bit valid;
    int fail_idx;
    int cnt;
    int addr_cap;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;

  logic       busy_a, done_a, valid_a, wren_a;
  logic [4:0] fail_a, addr_a;
  logic [5:0] cnt_a;
  logic [7:0] q_a;
  logic       busy_b, done_b, valid_b, wren_b;
  logic [4:0] fail_b, addr_b;
  logic [5:0] cnt_b;
  logic [7:0] q_b;

  logic [7:0] mem    [MSG_LEN];
  logic [7:0] pipe_a [LAT_A];
  logic [7:0] pipe_b [LAT_B];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   c_now;
  bit   chk_en = 1'b0;
  exp_t e_a, e_b;
  int   first_done_a, first_done_b, max_addr_a;

  msg_charset_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(5), .RD_LATENCY(LAT_A), .EARLY_ABORT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy_a), .done(done_a), .valid(valid_a), .fail_index(fail_a), .valid_count(cnt_a),
    .mem_addr(addr_a), .mem_wren(wren_a), .mem_q(q_a)
  );

  msg_charset_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(5), .RD_LATENCY(LAT_B), .EARLY_ABORT(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy_b), .done(done_b), .valid(valid_b), .fail_index(fail_b), .valid_count(cnt_b),
    .mem_addr(addr_b), .mem_wren(wren_b), .mem_q(q_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Fixed-latency RAM read ports.
  always @(posedge clk) begin
    pipe_a[0] <= mem[addr_a];
    for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
    pipe_b[0] <= mem[addr_b];
    for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign q_a = pipe_a[LAT_A-1];
  assign q_b = pipe_b[LAT_B-1];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit str_has(input string s, input logic [7:0] b);
    for (int i = 0; i < s.len(); i++) if (s[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_set(input logic [1:0] m, input logic [7:0] b);
    string lower = "abcdefghijklmnopqrstuvwxyz ";
    string upper = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string extra = "0123456789.,";
    if (m == 2'd3) return (int'(b) >= 32) && (int'(b) <= 126);
    if (str_has(lower, b)) return 1'b1;
    if (m >= 2'd1 && str_has(upper, b)) return 1'b1;
    if (m >= 2'd2 && str_has(extra, b)) return 1'b1;
    return 1'b0;
  endfunction

  // Whole-pass outcome from the message contents alone.
  function automatic exp_t model(input int lat, input bit ea, input logic [1:0] m);
    exp_t e;
    e.done_cyc = MSG_LEN + lat + 1;
    e.valid    = 1'b1;
    e.fail_idx = 0;
    e.cnt      = 0;
    e.addr_cap = MSG_LEN - 1;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (in_set(m, mem[i])) e.cnt++;
      else if (e.valid) begin
        e.valid    = 1'b0;
        e.fail_idx = i;
        if (ea) begin
          e.done_cyc = 2 + i + lat;
          e.addr_cap = (i + lat < MSG_LEN - 1) ? i + lat : MSG_LEN - 1;
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic cmp(input string n, input exp_t e, input int c, input logic busy, input logic done,
                     input logic valid, input logic [4:0] fi, input logic [5:0] cnt,
                     input logic [4:0] addr, input logic wren);
    int addr_exp;
    addr_exp = (c - 1 > e.addr_cap) ? e.addr_cap : c - 1;
    check({n, ".busy"}, int'(busy), int'(c < e.done_cyc));
    check({n, ".done"}, int'(done), int'(c >= e.done_cyc));
    if (c >= e.done_cyc) begin
      check({n, ".valid"}, int'(valid), int'(e.valid));
      check({n, ".fail_index"}, int'(fi), e.fail_idx);
      check({n, ".valid_count"}, int'(cnt), e.cnt);
    end else begin
      check({n, ".valid_early"}, int'(valid), 0);
    end
    check({n, ".mem_addr"}, int'(addr), addr_exp);
    check({n, ".mem_wren"}, int'(wren), 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      c_now = cyc - start_cyc;
      if (c_now >= 1) begin
        cmp("A", e_a, c_now, busy_a, done_a, valid_a, fail_a, cnt_a, addr_a, wren_a);
        cmp("B", e_b, c_now, busy_b, done_b, valid_b, fail_b, cnt_b, addr_b, wren_b);
        if (done_a && first_done_a < 0) first_done_a = c_now;
        if (done_b && first_done_b < 0) first_done_b = c_now;
        if (int'(addr_a) > max_addr_a) max_addr_a = int'(addr_a);
      end
    end
  end

  task automatic check_all_zero(input string n);
    check({n, " A.busy"}, int'(busy_a), 0);
    check({n, " A.done"}, int'(done_a), 0);
    check({n, " A.valid"}, int'(valid_a), 0);
    check({n, " A.fail_index"}, int'(fail_a), 0);
    check({n, " A.valid_count"}, int'(cnt_a), 0);
    check({n, " A.mem_addr"}, int'(addr_a), 0);
    check({n, " A.mem_wren"}, int'(wren_a), 0);
    check({n, " B.busy"}, int'(busy_b), 0);
    check({n, " B.done"}, int'(done_b), 0);
    check({n, " B.valid"}, int'(valid_b), 0);
    check({n, " B.valid_count"}, int'(cnt_b), 0);
    check({n, " B.mem_addr"}, int'(addr_b), 0);
  endtask

  task automatic fill_lower();
    string s = "abcdefghijklmnopqrstuvwxyz ";
    for (int i = 0; i < MSG_LEN; i++) mem[i] = s[$urandom_range(0, s.len() - 1)];
  endtask

  task automatic fill_random();
    string s = "abcdefghijklmnopqrstuvwxyz ";
    int r;
    for (int i = 0; i < MSG_LEN; i++) begin
      r = $urandom_range(0, 99);
      if (r < 88)      mem[i] = s[$urandom_range(0, s.len() - 1)];
      else if (r < 96) mem[i] = 8'($urandom_range(32, 126));
      else             mem[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Runs a full pass; mode is scrambled after cycle 0 to show it was latched.
  task automatic run_pass(input logic [1:0] m, input bit mid_start);
    int total;
    @(posedge clk); #1;
    e_a = model(LAT_A, 1'b1, m);
    e_b = model(LAT_B, 1'b0, m);
    first_done_a = -1;
    first_done_b = -1;
    max_addr_a   = 0;
    start = 1'b1;
    mode = m;
    start_cyc = cyc;
    chk_en = 1'b1;
    total = ((e_a.done_cyc > e_b.done_cyc) ? e_a.done_cyc : e_b.done_cyc) + 3;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      start = mid_start && (c == 5);
      mode  = (mid_start && c == 5) ? 2'd3 : 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    string hello = "Hello World";
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // T1: clean lowercase message, start re-pulsed mid-SCAN must be ignored.
    fill_lower();
    run_pass(2'd0, 1'b1);
    check("T1 A.done_cycle", first_done_a, 35);
    check("T1 A.valid", int'(valid_a), 1);
    check("T1 A.valid_count", int'(cnt_a), 32);
    check("T1 A.fail_index", int'(fail_a), 0);
    check("T1 B.done_cycle", first_done_b, 36);

    // T2: 'A' at byte 5 in mode 0.
    fill_lower();
    mem[5] = 8'h41;
    run_pass(2'd0, 1'b0);
    check("T2 A.done_cycle", first_done_a, 9);
    check("T2 A.valid", int'(valid_a), 0);
    check("T2 A.fail_index", int'(fail_a), 5);
    check("T2 A.valid_count", int'(cnt_a), 5);
    check("T2 A.max_addr", max_addr_a, 7);
    check("T2 B.valid_count", int'(cnt_b), 31);

    // T3: two '{' bytes; the full-scan instance keeps the first.
    fill_lower();
    mem[3]  = 8'h7B;
    mem[20] = 8'h7B;
    run_pass(2'd0, 1'b0);
    check("T3 B.done_cycle", first_done_b, 36);
    check("T3 B.fail_index", int'(fail_b), 3);
    check("T3 B.valid_count", int'(cnt_b), 30);
    check("T3 A.valid_count", int'(cnt_a), 3);

    // T4: "Hello World" fails lowercase-only, passes with capitals.
    for (int i = 0; i < MSG_LEN; i++) mem[i] = (i < hello.len()) ? hello[i] : 8'h20;
    run_pass(2'd0, 1'b0);
    check("T4 mode0 A.valid", int'(valid_a), 0);
    check("T4 mode0 A.fail_index", int'(fail_a), 0);
    check("T4 mode0 A.done_cycle", first_done_a, 4);
    run_pass(2'd1, 1'b0);
    check("T4 mode1 A.valid", int'(valid_a), 1);
    check("T4 mode1 B.valid_count", int'(cnt_b), 32);

    // T5: printable-range boundaries, only 0x7F is outside.
    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h61;
    mem[0] = 8'h60; mem[1] = 8'h61; mem[2] = 8'h7A;
    mem[3] = 8'h7B; mem[4] = 8'h20; mem[5] = 8'h7F;
    run_pass(2'd3, 1'b0);
    check("T5 B.done_cycle", first_done_b, 36);
    check("T5 B.fail_index", int'(fail_b), 5);
    check("T5 B.valid_count", int'(cnt_b), 31);
    run_pass(2'd0, 1'b0);
    check("T5 mode0 A.fail_index", int'(fail_a), 0);

    // T6: reset (with start) at cycle 10 of a pass.
    fill_lower();
    @(posedge clk); #1;
    e_a = model(LAT_A, 1'b1, 2'd0);
    e_b = model(LAT_B, 1'b0, 2'd0);
    start = 1'b1;
    mode = 2'd0;
    start_cyc = cyc;
    chk_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk_en = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("T6");
    repeat (3) begin
      @(negedge clk);
      check("T6 idle A.busy", int'(busy_a), 0);
      check("T6 idle B.done", int'(done_b), 0);
    end

    // Recovery and randomized passes.
    for (int p = 0; p < 24; p++) begin
      fill_random();
      run_pass(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)) && (p > 0) && 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
